seg_chase_decoder: RTL and testbench

SEG_CHASE_DECODER -- requirements
Module: seg_chase_decoder

---
 rtl/seg_chase_decoder_if.sv | 24 ++
 rtl/seg_chase_decoder.sv | 125 ++++++++++++
 tb/tb_seg_chase_decoder.sv | 142 ++++++++++++++
 3 files changed

// File: rtl/seg_chase_decoder_if.sv
// Segment bus in, decoded chase position/step/period/error out.
// master drives the segment bus and reads back the decode results; slave is the decoder.
interface seg_chase_decoder_if #(
  parameter int PERIOD_WIDTH = 16
);
  logic [7:0]              seg_n_in;
  logic [2:0]              pos;
  logic                    pos_valid;
  logic                    dir;
  logic                    step;
  logic [PERIOD_WIDTH-1:0] period;
  logic                    period_valid;
  logic                    err;

  modport master (
    output seg_n_in,
    input  pos, pos_valid, dir, step, period, period_valid, err
  );

  modport slave (
    input  seg_n_in,
    output pos, pos_valid, dir, step, period, period_valid, err
  );
endinterface

// File: rtl/seg_chase_decoder.sv
// Decodes a single-segment "chase" pattern (a,b,g,e,d,c,g,f) into a position, direction,
// step pulse and step period, flagging illegal patterns and non-neighbour jumps.
module seg_chase_decoder #(
  parameter int SYNC_STAGES  = 2,
  parameter int PERIOD_WIDTH = 16
) (
  input  logic               clk,
  input  logic               reset,
  seg_chase_decoder_if.slave bus
);
  typedef enum logic {ACQUIRE, TRACK} state_t;
  localparam logic [PERIOD_WIDTH-1:0] CNT_MAX = '1;

  // Segment lit at each chase position; g appears twice (positions 2 and 6).
  function automatic logic [6:0] seg_of(input logic [2:0] p);
    case (p)
      3'd0:    seg_of = 7'h01;
      3'd1:    seg_of = 7'h02;
      3'd2:    seg_of = 7'h40;
      3'd3:    seg_of = 7'h10;
      3'd4:    seg_of = 7'h08;
      3'd5:    seg_of = 7'h04;
      3'd6:    seg_of = 7'h40;
      default: seg_of = 7'h20;
    endcase
  endfunction

  logic [SYNC_STAGES-1:0][7:0] sync_q;
  logic [7:0]                  seg, prev_pat;
  state_t                      state;
  logic [PERIOD_WIDTH-1:0]     cnt, period_q;
  logic [2:0]                  pos_q;
  logic                        pos_valid_q, dir_q, step_q, period_valid_q, err_q, armed;

  always_ff @(posedge clk) begin
    if (reset) sync_q <= '1;
    else       sync_q <= {sync_q[SYNC_STAGES-2:0], bus.seg_n_in};
  end

  assign seg = ~sync_q[SYNC_STAGES-1];

  logic       is_blank, legal, change, hit_up, hit_dn, step_now, fault, acq_ok;
  logic [2:0] pos_p1, pos_m1, acq_pos;

  always_comb begin
    is_blank = (seg == 8'h00);
    legal    = !seg[7] && (seg[6:0] != 7'h00) && ((seg[6:0] & (seg[6:0] - 7'd1)) == 7'h00);
    change   = !is_blank && (seg != prev_pat);
    pos_p1   = pos_q + 3'd1;
    pos_m1   = pos_q - 3'd1;
    hit_up   = change && legal && (seg[6:0] == seg_of(pos_p1));
    hit_dn   = change && legal && (seg[6:0] == seg_of(pos_m1));
    step_now = (state == TRACK) && (hit_up || hit_dn);
    fault    = (state == TRACK) &&
               ((!legal && !is_blank) || (change && legal && !hit_up && !hit_dn));
    acq_ok   = 1'b1;
    acq_pos  = 3'd0;
    case (seg)
      8'h01:   acq_pos = 3'd0;
      8'h02:   acq_pos = 3'd1;
      8'h10:   acq_pos = 3'd3;
      8'h08:   acq_pos = 3'd4;
      8'h04:   acq_pos = 3'd5;
      8'h20:   acq_pos = 3'd7;
      default: acq_ok  = 1'b0;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      prev_pat       <= 8'h00;
      state          <= ACQUIRE;
      cnt            <= '0;
      pos_q          <= 3'd0;
      pos_valid_q    <= 1'b0;
      dir_q          <= 1'b0;
      step_q         <= 1'b0;
      period_q       <= '0;
      period_valid_q <= 1'b0;
      err_q          <= 1'b0;
      armed          <= 1'b0;
    end else begin
      if (!is_blank) prev_pat <= seg;
      step_q <= 1'b0;
      if (step_now)            cnt <= '0;
      else if (cnt != CNT_MAX) cnt <= cnt + 1'b1;
      case (state)
        ACQUIRE: begin
          if (!legal && !is_blank) err_q <= 1'b1;
          else if (acq_ok) begin
            pos_q       <= acq_pos;
            pos_valid_q <= 1'b1;
            armed       <= 1'b0;
            state       <= TRACK;
          end
        end
        TRACK: begin
          if (step_now) begin
            pos_q    <= hit_up ? pos_p1 : pos_m1;
            dir_q    <= hit_up;
            step_q   <= 1'b1;
            period_q <= (cnt == CNT_MAX) ? CNT_MAX : cnt + 1'b1;
            // the first step after lock only opens the measurement window
            if (armed) period_valid_q <= 1'b1;
            armed    <= 1'b1;
          end else if (fault) begin
            err_q          <= 1'b1;
            pos_valid_q    <= 1'b0;
            period_valid_q <= 1'b0;
            state          <= ACQUIRE;
          end
        end
        default: state <= ACQUIRE;
      endcase
    end
  end

  assign bus.pos          = pos_q;
  assign bus.pos_valid    = pos_valid_q;
  assign bus.dir          = dir_q;
  assign bus.step         = step_q;
  assign bus.period       = period_q;
  assign bus.period_valid = period_valid_q;
  assign bus.err          = err_q;
endmodule

// File: tb/tb_seg_chase_decoder.sv
// Directed bench for seg_chase_decoder: lock, forward/reverse chase, jump, illegal, reset, saturation.
module tb_seg_chase_decoder;
  logic clk = 1'b0;
  logic reset;
  int   n_cmp = 0;
  int   n_err = 0;
  int   n_steps = 0;

  always #5 clk = ~clk;

  seg_chase_decoder_if #(.PERIOD_WIDTH(16)) if16 ();
  seg_chase_decoder_if #(.PERIOD_WIDTH(4))  if4 ();

  seg_chase_decoder #(.SYNC_STAGES(2), .PERIOD_WIDTH(16)) dut16 (.clk(clk), .reset(reset), .bus(if16));
  seg_chase_decoder #(.SYNC_STAGES(2), .PERIOD_WIDTH(4))  dut4  (.clk(clk), .reset(reset), .bus(if4));

  always @(posedge clk) if (if16.step) n_steps <= n_steps + 1;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  logic [7:0] fwd [8] = '{8'hFD, 8'hBF, 8'hEF, 8'hF7, 8'hFB, 8'hBF, 8'hDF, 8'hFE};
  logic [7:0] rev [3] = '{8'hDF, 8'hBF, 8'hFB};
  logic [2:0] rev_pos [3] = '{3'd7, 3'd6, 3'd5};

  initial begin
    reset = 1'b1;
    if16.seg_n_in = 8'hFE;
    if4.seg_n_in  = 8'hFF;
    tick(3);
    chk("rst_pos", if16.pos, 0);
    chk("rst_pos_valid", if16.pos_valid, 0);
    chk("rst_err", if16.err, 0);
    chk("rst_period", if16.period, 0);

    // lock on a: pos_valid rises on the third edge after release
    reset = 1'b0;
    tick(2);
    chk("lock_early", if16.pos_valid, 0);
    tick(1);
    chk("lock_pos_valid", if16.pos_valid, 1);
    chk("lock_pos", if16.pos, 0);
    chk("lock_step", if16.step, 0);
    chk("lock_err", if16.err, 0);

    for (int k = 0; k < 8; k++) begin
      if16.seg_n_in = fwd[k];
      tick(10);
      chk($sformatf("fwd_pos%0d", k), if16.pos, (k + 1) % 8);
      chk($sformatf("fwd_dir%0d", k), if16.dir, 1);
      chk($sformatf("fwd_pv%0d", k), if16.period_valid, (k >= 1) ? 1 : 0);
      if (k >= 1) chk($sformatf("fwd_period%0d", k), if16.period, 10);
    end
    chk("fwd_steps", n_steps, 8);
    chk("fwd_err", if16.err, 0);

    for (int k = 0; k < 3; k++) begin
      if16.seg_n_in = rev[k];
      tick(10);
      chk($sformatf("rev_pos%0d", k), if16.pos, rev_pos[k]);
      chk($sformatf("rev_dir%0d", k), if16.dir, 0);
    end

    if16.seg_n_in = 8'hFF;
    tick(10);
    chk("blank_pos", if16.pos, 5);
    chk("blank_pv", if16.pos_valid, 1);
    chk("blank_err", if16.err, 0);
    if16.seg_n_in = 8'hBF;
    tick(10);
    chk("g_after_blank_pos", if16.pos, 6);
    chk("g_after_blank_dir", if16.dir, 1);
    chk("steps_total", n_steps, 12);

    // reset lands on the same edge the f step would be taken
    if16.seg_n_in = 8'hDF;
    tick(2);
    reset = 1'b1;
    tick(1);
    chk("rstprio_step", if16.step, 0);
    chk("rstprio_pos", if16.pos, 0);
    chk("rstprio_pv", if16.pos_valid, 0);
    reset = 1'b0;
    if16.seg_n_in = 8'hFE;
    tick(5);
    chk("relock_pos", if16.pos, 0);
    chk("relock_pv", if16.pos_valid, 1);

    // jump a -> e
    if16.seg_n_in = 8'hEF;
    tick(3);
    chk("jump_err", if16.err, 1);
    chk("jump_pv", if16.pos_valid, 0);
    chk("jump_pos_held", if16.pos, 0);
    tick(1);
    chk("reacq_pv", if16.pos_valid, 1);
    chk("reacq_pos", if16.pos, 3);
    chk("reacq_err", if16.err, 1);

    // dp set is illegal
    if16.seg_n_in = 8'h7E;
    tick(4);
    chk("ill_err", if16.err, 1);
    chk("ill_pv", if16.pos_valid, 0);
    chk("ill_period_valid", if16.period_valid, 0);
    reset = 1'b1;
    tick(1);
    chk("rst2_pos", if16.pos, 0);
    chk("rst2_pv", if16.pos_valid, 0);
    chk("rst2_dir", if16.dir, 0);
    chk("rst2_step", if16.step, 0);
    chk("rst2_period", if16.period, 0);
    chk("rst2_period_valid", if16.period_valid, 0);
    chk("rst2_err", if16.err, 0);

    // 4-bit period saturates at 15 for 20-cycle steps
    reset = 1'b0;
    if4.seg_n_in = 8'hFE;
    tick(5);
    if4.seg_n_in = 8'hFD;
    tick(20);
    chk("sat_pv_first", if4.period_valid, 0);
    if4.seg_n_in = 8'hBF;
    tick(20);
    chk("sat_pos", if4.pos, 2);
    chk("sat_period", if4.period, 15);
    chk("sat_pv", if4.period_valid, 1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
